mcl_req_word_packer: RTL and testbench

- Sits between the host AXI-Lite write path of the manycore-link (MCL) master FIFO window and the MCL request injection port.
- Accepts 32-bit host words, assembles each group of four into one 128-bit bsg_mcl_request_s packet, and buffers assembled packets.
- Releases buffered packets downstream only while host request credits remain.
- Exports word vacancy and credit count so the AXI-Lite register file can expose them at its vacancy and credit offsets.

---
 rtl/mcl_req_word_packer.sv | 135 +++++++++++++
 tb/tb_mcl_req_word_packer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mcl_req_word_packer.sv
// mcl_req_word_packer
//   Packs groups of four 32-bit host words into 128-bit bsg_mcl_request_s
//   packets. Assembled packets are buffered in a small FIFO and released
//   downstream only while host request credits remain.
//
//   Word n of a group lands in pkt bits [32n+31:32n]:
//     word0 = {src_y_cord, src_x_cord, y_cord, x_cord}, payload [63:32],
//     op_ex [71:64], op [79:72], addr [111:80], padding [127:112].
//
// Ports
//   clk_i, reset_i     clock, asynchronous active-high reset
//   word_v_i/word_i    host word valid / data
//   word_ready_o       host word accepted when word_v_i & word_ready_o
//   pkt_v_o/pkt_o      assembled packet valid / data (head of buffer)
//   pkt_ready_i        downstream accept
//   credit_return_i    one host request credit returned this cycle
//   credits_o          credits currently available
//   vacancy_o          32-bit words the block can still accept
//   err_o              sticky packet-rejected flag
//
// Build option
//   MCL_REQ_PACKER_OP_CHECK_EN : when defined, a packet whose op byte is
//   above 8'h02 is dropped on completion and err_o latches high until reset.
//   When undefined every packet is buffered and err_o is tied low.

module mcl_req_word_packer #(
  parameter int unsigned els_p          = 2,
  parameter int unsigned max_credits_p  = 16,
  parameter int unsigned credit_width_p = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      word_v_i,
  input  logic [31:0]               word_i,
  output logic                      word_ready_o,
  output logic                      pkt_v_o,
  output logic [127:0]              pkt_o,
  input  logic                      pkt_ready_i,
  input  logic                      credit_return_i,
  output logic [credit_width_p-1:0] credits_o,
  output logic [31:0]               vacancy_o,
  output logic                      err_o
);

  localparam int unsigned cnt_w = $clog2(els_p + 1);
  localparam int unsigned ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [credit_width_p-1:0] max_c = credit_width_p'(max_credits_p);

  logic [1:0]                wcnt_r;
  logic [95:0]               stage_r;
  logic [127:0]              mem_r [els_p];
  logic [ptr_w-1:0]          rptr_r, wptr_r;
  logic [cnt_w-1:0]          count_r;
  logic [credit_width_p-1:0] credits_r;

  logic        full, pop, accept, last, op_ok, push;
  logic [31:0] free_words;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count_r == cnt_w'(els_p));
  assign pkt_v_o      = (count_r != '0) && (credits_r != '0);
  assign pop          = pkt_v_o && pkt_ready_i;
  // Final word may enter a full buffer when the head leaves in the same cycle.
  assign word_ready_o = (wcnt_r != 2'd3) || !full || pop;
  assign accept       = word_v_i && word_ready_o;
  assign last         = accept && (wcnt_r == 2'd3);
  assign push         = last && op_ok;
  assign pkt_o        = mem_r[rptr_r];
  assign credits_o    = credits_r;

`ifdef MCL_REQ_PACKER_OP_CHECK_EN
  assign op_ok = (stage_r[79:72] <= 8'h02);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)            err_o <= 1'b0;
    else if (last && !op_ok) err_o <= 1'b1;
  end
`else
  assign op_ok = 1'b1;
  assign err_o = 1'b0;
`endif

  // Words held in staging while the buffer is full would make the raw
  // difference negative; report zero room instead of wrapping.
  assign free_words = (32'(els_p) - 32'(count_r)) << 2;
  assign vacancy_o  = (free_words >= 32'(wcnt_r)) ? free_words - 32'(wcnt_r) : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wcnt_r  <= '0;
      stage_r <= '0;
    end else if (accept) begin
      wcnt_r <= wcnt_r + 2'd1;
      case (wcnt_r)
        2'd0:    stage_r[31:0]  <= word_i;
        2'd1:    stage_r[63:32] <= word_i;
        2'd2:    stage_r[95:64] <= word_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < els_p; i++) mem_r[i] <= '0;
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        mem_r[wptr_r] <= {word_i, stage_r};
        wptr_r        <= ptr_inc(wptr_r);
      end
      if (pop) rptr_r <= ptr_inc(rptr_r);
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      credits_r <= max_c;
    else if (pop && !credit_return_i)
      credits_r <= credits_r - 1'b1;
    else if (credit_return_i && !pop && (credits_r != max_c))
      credits_r <= credits_r + 1'b1;
  end

endmodule

// File: tb/tb_mcl_req_word_packer.sv
// Testbench for mcl_req_word_packer: directed scenarios followed by random
// traffic, each cycle compared against a queue-based reference model.

module tb_mcl_req_word_packer;

  localparam int unsigned EL  = 2;
  localparam int unsigned MAX = 16;
  localparam int unsigned CW  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          word_v = 1'b0;
  logic [31:0]   word = '0;
  logic          word_ready;
  logic          pkt_v;
  logic [127:0]  pkt;
  logic          pkt_ready = 1'b0;
  logic          credit_return = 1'b0;
  logic [CW-1:0] credits;
  logic [31:0]   vacancy;
  logic          err;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Reference model state
  logic [127:0] mq[$];
  logic [31:0]  ms[$];
  int           m_cred;
  logic         m_err;

  mcl_req_word_packer #(
    .els_p(EL),
    .max_credits_p(MAX),
    .credit_width_p(CW)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .word_v_i(word_v),
    .word_i(word),
    .word_ready_o(word_ready),
    .pkt_v_o(pkt_v),
    .pkt_o(pkt),
    .pkt_ready_i(pkt_ready),
    .credit_return_i(credit_return),
    .credits_o(credits),
    .vacancy_o(vacancy),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    ms.delete();
    m_cred = MAX;
    m_err  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    word_v = 1'b0; pkt_ready = 1'b0; credit_return = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check against the model,
  // then advance the model by what the rising edge will do.
  task automatic step(input logic wv, input logic [31:0] w, input logic rdy, input logic cr);
    logic         e_pv, e_pop, e_rdy, acc;
    int           vac;
    logic [127:0] p;
    @(negedge clk);
    word_v = wv; word = w; pkt_ready = rdy; credit_return = cr;
    #1;
    e_pv  = (mq.size() > 0) && (m_cred > 0);
    e_pop = e_pv && rdy;
    e_rdy = (ms.size() < 3) || (mq.size() < EL) || e_pop;
    vac   = (int'(EL) - int'(mq.size())) * 4 - int'(ms.size());
    if (vac < 0) vac = 0;
    chk("pkt_v", 128'(pkt_v), 128'(e_pv));
    if (e_pv) chk("pkt", pkt, mq[0]);
    chk("word_ready", 128'(word_ready), 128'(e_rdy));
    chk("credits", 128'(credits), 128'(m_cred));
    chk("vacancy", 128'(vacancy), 128'(vac));
    chk("err", 128'(err), 128'(m_err));
    acc = wv && e_rdy;
    if (e_pop) void'(mq.pop_front());
    if (e_pop && !cr) m_cred--;
    else if (cr && !e_pop && m_cred < int'(MAX)) m_cred++;
    if (acc) begin
      if (ms.size() == 3) begin
        p = {w, ms[2], ms[1], ms[0]};
`ifdef MCL_REQ_PACKER_OP_CHECK_EN
        if (ms[2][15:8] > 8'h02) m_err = 1'b1;
        else mq.push_back(p);
`else
        mq.push_back(p);
`endif
        ms.delete();
      end else begin
        ms.push_back(w);
      end
    end
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    #12;
    reset = 1'b0;

    // Reset state, then the reference packet and one pop
    step(0, '0, 0, 0);
    step(1, 32'h0403_0201, 0, 0);
    step(1, 32'hAAAA_5555, 0, 0);
    step(1, 32'h0000_0100, 0, 0);
    step(1, 32'h1234_5678, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    chk("tp1_credits", 128'(credits), 128'(15));

    // Fill both entries plus a staged packet; final word stalls until a pop
    do_reset();
    for (int i = 0; i < 11; i++) step(1, 32'(i) * 32'h0101_0003 & 32'hFFFF_00FF, 0, 0);
    step(1, 32'hCAFE_0011, 0, 0);
    step(1, 32'hCAFE_0011, 0, 0);
    step(1, 32'hCAFE_0011, 1, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

    // Exhaust credits, then one return releases the held packet
    do_reset();
    for (int i = 0; i < 72; i++) step(1, $urandom & 32'hFFFF_00FF, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);

    // Credit saturation and pop with simultaneous return
    do_reset();
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, $urandom & 32'hFFFF_00FF, 0, 0);
    step(0, '0, 1, 1);
    step(0, '0, 0, 0);

    // Asynchronous reset mid-packet, then a clean packet
    do_reset();
    step(1, 32'h1111_1111, 0, 0);
    step(1, 32'h2222_2222, 0, 0);
    @(negedge clk);
    word_v = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_vacancy", 128'(vacancy), 128'(EL * 4));
    chk("arst_pkt_v", 128'(pkt_v), 128'(0));
    chk("arst_ready", 128'(word_ready), 128'(1));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 32'h0A0B_0000 + 32'(i), 0, 0);
    step(0, '0, 1, 0);

`ifdef MCL_REQ_PACKER_OP_CHECK_EN
    // Illegal op byte drops the packet and latches the error
    do_reset();
    step(1, 32'h0000_0000, 0, 0);
    step(1, 32'h0000_0001, 0, 0);
    step(1, 32'h0000_0500, 0, 0);
    step(1, 32'h0000_0003, 0, 0);
    step(0, '0, 1, 0);
    chk("opchk_err", 128'(err), 128'(1));
    for (int i = 0; i < 4; i++) step(1, 32'h0000_0200 * 32'(i == 2), 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
